// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - byte-write I2C master: START, three bytes with ACK slots, STOP.
// Optional macro I2C_STRETCH_EN: open-drain SCL with slave clock stretching.
module i2c_write_master #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ = 400_000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] I2C_DATA,
  input  logic        START,
  output logic        END,
  output logic        ACK,
`ifdef I2C_STRETCH_EN
  inout  wire         I2C_SCL,
`else
  output logic        I2C_SCL,
`endif
  inout  wire         I2C_SDA
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_STRT, S_BIT, S_ACKS, S_STOP, S_DONE} state_t;

  state_t        state;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   shreg;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          scl_r;
  logic          sda_low;
  logic          busy;
  logic          hold;
  logic          tick;
  logic          last_q;

  // Line levels for a given phase, returned as {scl, sda_low}.
  function automatic logic [1:0] drive(input state_t s, input logic [1:0] qq, input logic b);
    case (s)
      S_STRT:  drive = {1'b1, qq[0]};
      S_BIT:   drive = {(qq == 2'd1) || (qq == 2'd2), ~b};
      S_ACKS:  drive = {(qq == 2'd1) || (qq == 2'd2), 1'b0};
      S_STOP:  drive = {qq != 2'd0, qq != 2'd2};
      default: drive = 2'b10;
    endcase
  endfunction

  assign busy   = (state == S_STRT) || (state == S_BIT) || (state == S_ACKS) || (state == S_STOP);
  assign last_q = (state == S_STRT && q == 2'd1) || (state == S_STOP && q == 2'd2) || (q == 2'd3);
  assign tick   = busy && !hold && (cnt == CW'(DIV - 1));

`ifdef I2C_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) scl_sync <= 2'b11;
    else         scl_sync <= {scl_sync[0], I2C_SCL};
  end

  // A slave holding SCL low during a high quarter freezes the quarter timer.
  assign hold    = !scl_sync[1] &&
                   ((((state == S_BIT) || (state == S_ACKS)) && q == 2'd1) ||
                    ((state == S_STOP) && q != 2'd0));
  assign I2C_SCL = scl_r ? 1'bz : 1'b0;
`else
  assign hold    = 1'b0;
  assign I2C_SCL = scl_r;
`endif

  assign I2C_SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state    <= S_IDLE;
      q        <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
      cnt      <= '0;
      armed    <= 1'b1;
      END      <= 1'b1;
      ACK      <= 1'b0;
      scl_r    <= 1'b1;
      sda_low  <= 1'b0;
    end else begin
      if (!START) armed <= 1'b1;

      if (!busy || tick || hold) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (START && armed) begin
            shreg    <= I2C_DATA;
            END      <= 1'b0;
            ACK      <= 1'b0;
            armed    <= 1'b0;
            state    <= S_STRT;
            q        <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            {scl_r, sda_low} <= drive(S_STRT, 2'd0, 1'b1);
          end
        end
        S_STRT, S_BIT, S_ACKS, S_STOP: begin
          if (tick) begin
            if (!last_q) begin
              q <= q + 2'd1;
              {scl_r, sda_low} <= drive(state, q + 2'd1, shreg[23]);
              if (state == S_ACKS && q == 2'd1 && I2C_SDA) ACK <= 1'b1;
            end else begin
              q <= 2'd0;
              case (state)
                S_STRT: begin
                  state <= S_BIT;
                  {scl_r, sda_low} <= drive(S_BIT, 2'd0, shreg[23]);
                end
                S_BIT: begin
                  shreg   <= {shreg[22:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    state <= S_ACKS;
                    {scl_r, sda_low} <= drive(S_ACKS, 2'd0, 1'b1);
                  end else begin
                    {scl_r, sda_low} <= drive(S_BIT, 2'd0, shreg[22]);
                  end
                end
                S_ACKS: begin
                  // A NACK skips the remaining bytes straight to STOP.
                  if (ACK || byte_cnt == 2'd2) begin
                    state <= S_STOP;
                    {scl_r, sda_low} <= drive(S_STOP, 2'd0, 1'b1);
                  end else begin
                    state    <= S_BIT;
                    byte_cnt <= byte_cnt + 2'd1;
                    {scl_r, sda_low} <= drive(S_BIT, 2'd0, shreg[23]);
                  end
                end
                default: begin
                  state <= S_DONE;
                  {scl_r, sda_low} <= 2'b10;
                end
              endcase
            end
          end
        end
        S_DONE: begin
          END   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
